// File: rtl/game_clock_if.sv
// Signal bundle between the level sequencer and game_clock.
// Defining GAME_CLOCK_PAUSE_EN adds the pause input to both modports.
interface game_clock_if;
  logic        btn_raw;
  logic        playerDied;
  logic        run;
`ifdef GAME_CLOCK_PAUSE_EN
  logic        pause;
`endif
  logic        slowClk;
  logic [10:0] game_time;
  logic        time_sat;
  logic        userSel;

`ifdef GAME_CLOCK_PAUSE_EN
  modport master (
    output btn_raw, playerDied, run, pause,
    input  slowClk, game_time, time_sat, userSel
  );
  modport slave (
    input  btn_raw, playerDied, run, pause,
    output slowClk, game_time, time_sat, userSel
  );
`else
  modport master (
    output btn_raw, playerDied, run,
    input  slowClk, game_time, time_sat, userSel
  );
  modport slave (
    input  btn_raw, playerDied, run,
    output slowClk, game_time, time_sat, userSel
  );
`endif
endinterface

// File: rtl/game_clock.sv
// Frame tick divider, saturating 11-bit level timer and select-button debouncer.
// Optional feature macro: GAME_CLOCK_PAUSE_EN (adds pause, which freezes the timer).
module game_clock #(
  parameter int unsigned TICK_DIV  = 833333,
  parameter int unsigned DB_CYCLES = 500000
) (
  input logic         clk,
  input logic         reset,
  game_clock_if.slave gc
);

  localparam logic [23:0] DIV_LAST = 24'(TICK_DIV - 1);
  localparam logic [19:0] DB_LAST  = 20'(DB_CYCLES - 1);
  localparam logic [10:0] TIME_MAX = 11'h7FF;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == TIME_MAX) ? v : v + 11'd1;
  endfunction

  logic [23:0] div_q, div_d;
  logic        wrap;
  logic        slow_q;
  logic [10:0] time_q, time_d;
  logic        sat_q;
  logic        hold;
  logic        s1_q, s2_q;
  logic        db_q, db_d, db_prev_q;
  logic [19:0] dbcnt_q, dbcnt_d;
  logic        sel_q;

`ifdef GAME_CLOCK_PAUSE_EN
  assign hold = gc.pause;
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    wrap  = (div_q == DIV_LAST);
    div_d = wrap ? 24'd0 : div_q + 24'd1;
  end

  // Clears beat the hold, and the hold beats the tick increment.
  always_comb begin
    time_d = time_q;
    if (gc.playerDied || !gc.run) begin
      time_d = 11'd0;
    end else if (wrap && !hold) begin
      time_d = sat_inc(time_q);
    end
  end

  // dbcnt_q counts earlier consecutive disagreeing samples; this one completes the run.
  always_comb begin
    db_d    = db_q;
    dbcnt_d = 20'd0;
    if (s2_q != db_q) begin
      if (dbcnt_q == DB_LAST) begin
        db_d = s2_q;
      end else begin
        dbcnt_d = dbcnt_q + 20'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= 24'd0;
      slow_q    <= 1'b0;
      time_q    <= 11'd0;
      sat_q     <= 1'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      dbcnt_q   <= 20'd0;
      sel_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      slow_q    <= wrap;
      time_q    <= time_d;
      sat_q     <= (time_d == TIME_MAX);
      s1_q      <= gc.btn_raw;
      s2_q      <= s1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      dbcnt_q   <= dbcnt_d;
      sel_q     <= db_q & ~db_prev_q;
    end
  end

  assign gc.slowClk   = slow_q;
  assign gc.game_time = time_q;
  assign gc.time_sat  = sat_q;
  assign gc.userSel   = sel_q;

endmodule
